// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between writeback and a queued auxiliary requester
module rf_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int REG_ADDR = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wb_we,
  input  logic [REG_ADDR-1:0] wb_addr,
  input  logic [WIDTH-1:0]    wb_data,
  input  logic                aux_valid,
  output logic                aux_ready,
  input  logic [REG_ADDR-1:0] aux_addr,
  input  logic [WIDTH-1:0]    aux_data,
  input  logic [REG_ADDR-1:0] q_addr1,
  input  logic [REG_ADDR-1:0] q_addr2,
  output logic                q_pend1,
  output logic                q_pend2,
  output logic                WE3,
  output logic [REG_ADDR-1:0] A3,
  output logic [WIDTH-1:0]    WD3,
  output logic                stall_req,
  output logic [CW-1:0]       fifo_count,
  output logic                proto_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [REG_ADDR-1:0] fa [FIFO_DEPTH];
  logic [WIDTH-1:0] fd [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [SW-1:0] wait_cnt;
  logic g_wb, g_aux, push, empty;
  always_comb begin
    empty = fifo_count == '0;
    g_wb = wb_we && wb_addr != '0;
    g_aux = !g_wb && !empty;
    aux_ready = fifo_count != CW'(FIFO_DEPTH);
    push = aux_valid && aux_ready && aux_addr != '0;
    stall_req = !aux_ready || wait_cnt >= SW'(STARVE_LIMIT);
    WE3 = g_wb || g_aux;
    A3 = g_wb ? wb_addr : g_aux ? fa[rd_ptr] : '0;
    WD3 = g_wb ? wb_data : g_aux ? fd[rd_ptr] : '0;
    q_pend1 = 1'b0;
    q_pend2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      q_pend1 = q_pend1 || (vld[i] && fa[i] == q_addr1);
      q_pend2 = q_pend2 || (vld[i] && fa[i] == q_addr2);
    end
    q_pend1 = q_pend1 && q_addr1 != '0;
    q_pend2 = q_pend2 && q_addr2 != '0;
  end
  // push and pop never hit the same slot: that needs the queue both empty and full
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld <= '0;
      fifo_count <= '0;
      wait_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (g_aux) rd_ptr <= rd_ptr + 1'b1;
      vld <= (vld & ~(FIFO_DEPTH'(g_aux) << rd_ptr)) | (FIFO_DEPTH'(push) << wr_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(g_aux);
      wait_cnt <= (empty || g_aux) ? '0 : wait_cnt == SW'(STARVE_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
      proto_err <= proto_err || (stall_req && g_wb);
    end
  always_ff @(posedge CLK)
    if (push) begin
      fa[wr_ptr] <= aux_addr;
      fd[wr_ptr] <= aux_data;
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: queue-based reference model with a scoreboard on the write port
module tb_rf_write_arbiter;
  localparam int D = 4;
  localparam int L = 8;
  logic CLK = 1'b0, RST = 1'b0;
  logic wb_we = 1'b0, aux_valid = 1'b0;
  logic [4:0] wb_addr = '0, aux_addr = '0, q_addr1 = '0, q_addr2 = '0;
  logic [31:0] wb_data = '0, aux_data = '0;
  logic aux_ready, q_pend1, q_pend2, WE3, stall_req, proto_err;
  logic [4:0] A3;
  logic [31:0] WD3;
  logic [2:0] fifo_count;
  int tests = 0, fails = 0;
  logic [36:0] mq[$];
  logic [36:0] exp_q[$];
  int hw = 0;
  logic err = 1'b0;

  rf_write_arbiter dut (
    .CLK(CLK), .RST(RST), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2),
    .WE3(WE3), .A3(A3), .WD3(WD3), .stall_req(stall_req), .fifo_count(fifo_count),
    .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // monitor: one expectation (or none) per cycle, sampled just before the posedge
  always @(negedge CLK) begin
    logic [36:0] e;
    #3;
    chk("we3", WE3, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (WE3) begin
        chk("a3", A3, e[36:32]);
        chk("wd3", WD3, e[31:0]);
      end
    end else if (!WE3) chk("idle_port", {A3, WD3}, 0);
  end

  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [4:0] qa1, input logic [4:0] qa2);
    int sz;
    logic wbg, p1, p2;
    @(negedge CLK);
    wb_we = we; wb_addr = wa; wb_data = wd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    q_addr1 = qa1; q_addr2 = qa2;
    #1;
    sz = mq.size();
    p1 = 1'b0; p2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i][36:32] == qa1) p1 = 1'b1;
      if (mq[i][36:32] == qa2) p2 = 1'b1;
    end
    chk("fifo_count", fifo_count, sz);
    chk("aux_ready", aux_ready, sz < D);
    chk("stall_req", stall_req, sz == D || hw >= L);
    chk("proto_err", proto_err, err);
    chk("q_pend1", q_pend1, p1 && qa1 != 0);
    chk("q_pend2", q_pend2, p2 && qa2 != 0);
    wbg = we && wa != 0;
    if (wbg) exp_q.push_back({wa, wd});
    else if (sz != 0) exp_q.push_back(mq[0]);
    if ((sz == D || hw >= L) && wbg) err = 1'b1;
    hw = (sz == 0 || !wbg) ? 0 : (hw < L ? hw + 1 : L);
    if (!wbg && sz != 0) void'(mq.pop_front());
    if (av && sz < D && aa != 0) mq.push_back({aa, ad});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    wb_we = 0; aux_valid = 0; q_addr1 = 0; q_addr2 = 0;
    #2 RST = 1'b0;
    #1;
    chk("rst_we3", WE3, 0);
    chk("rst_aux_ready", aux_ready, 1);
    chk("rst_stall", stall_req, 0);
    chk("rst_pend", {q_pend1, q_pend2}, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_proto_err", proto_err, 0);
    mq.delete();
    hw = 0;
    err = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    do_reset();
    step(0, 0, 0, 1, 5, 32'hA5, 0, 0);
    step(0, 0, 0, 1, 6, 32'hB6, 5, 6);
    idle(2);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h100 + i, 1, 5'(2 + i), 32'h200 + i, 5'(2 + i), 3);
    step(1, 1, 32'h1FF, 1, 7, 32'h777, 2, 5);
    idle(5);
    step(1, 1, 32'h11, 1, 10, 32'hAA, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 32'h300 + i, 0, 0, 0, 10, 0);
    idle(2);
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
    step(1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    step(1, 1, 32'h1, 1, 9, 32'h1, 9, 0);
    step(1, 2, 32'h2, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    step(1, 9, 32'h99, 1, 9, 32'h55, 9, 9);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 3, 32'h400 + i, 1, 5'(11 + i), 32'h500 + i, 11, 12);
    step(0, 0, 0, 0, 0, 0, 12, 13);
    do_reset();
    idle(4);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    do_reset();
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
